// File: rtl/doodle_frame_scheduler_if.sv
// Platform table write bus for doodle_frame_scheduler.
// A level generator or CPU drives it; the scheduler only listens.
interface doodle_frame_scheduler_if #(
    parameter int IDX_W = 3
);
    logic             plat_we;
    logic [IDX_W-1:0] plat_idx;
    logic [9:0]       plat_x;
    logic [9:0]       plat_y;
    logic             plat_valid;

    modport master (
        output plat_we, plat_idx, plat_x, plat_y, plat_valid
    );

    modport slave (
        input plat_we, plat_idx, plat_x, plat_y, plat_valid
    );
endinterface

// File: rtl/doodle_frame_scheduler.sv
// Per-frame scan of the doodle against a reloadable platform table.
// Emits landing / fell-off pulses and a divided physics step.
module doodle_frame_scheduler #(
    parameter int NUM_PLAT  = 8,
    parameter int PLAT_W    = 64,
    parameter int DOODLE_R  = 20,
    parameter int LAND_TOL  = 4,
    parameter int V_RES     = 480,
    parameter int FRAME_DIV = 2,
    localparam int IDX_W    = $clog2(NUM_PLAT)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             falling,
    input  logic [9:0]       doodle_x,
    input  logic [9:0]       doodle_y,
    doodle_frame_scheduler_if.slave wr,
    output logic             busy,
    output logic             step_en,
    output logic             land,
    output logic [IDX_W-1:0] land_idx,
    output logic [9:0]       land_y,
    output logic             miss,
    output logic             overrun
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SCAN,
        REPORT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [9:0]       dx_s;
    logic [9:0]       dy_s;
    logic             fall_s;
    logic             hit_f;
    logic [IDX_W-1:0] hit_idx;
    logic [9:0]       hit_y;
    logic [CNT_W-1:0] fcnt;

    logic [NUM_PLAT-1:0] tv;
    logic [9:0]          tx [NUM_PLAT];
    logic [9:0]          ty [NUM_PLAT];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tv <= '0;
        end else if (wr.plat_we) begin
            tv[wr.plat_idx] <= wr.plat_valid;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr.plat_we) begin
            tx[wr.plat_idx] <= wr.plat_x;
            ty[wr.plat_idx] <= wr.plat_y;
        end
    end

    // 11-bit sums so right edges near 1023 never wrap
    logic [10:0] x_reach;
    logic [10:0] x_right;
    logic [10:0] y_low;
    logic        hit_now;
    logic        hit_any;
    logic        last;

    assign x_reach = {1'b0, dx_s} + 11'(DOODLE_R);
    assign x_right = {1'b0, tx[idx]} + 11'(PLAT_W - 1 + DOODLE_R);
    assign y_low   = {1'b0, ty[idx]} + 11'(LAND_TOL);

    assign hit_now = (state == SCAN) && tv[idx] && fall_s
                  && (x_reach >= {1'b0, tx[idx]})
                  && ({1'b0, dx_s} <= x_right)
                  && (dy_s >= ty[idx])
                  && ({1'b0, dy_s} <= y_low);
    assign hit_any = hit_f || hit_now;
    assign last    = (idx == IDX_W'(NUM_PLAT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            idx      <= '0;
            dx_s     <= '0;
            dy_s     <= '0;
            fall_s   <= 1'b0;
            hit_f    <= 1'b0;
            hit_idx  <= '0;
            hit_y    <= '0;
            fcnt     <= '0;
            busy     <= 1'b0;
            step_en  <= 1'b0;
            land     <= 1'b0;
            land_idx <= '0;
            land_y   <= '0;
            miss     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            land    <= 1'b0;
            miss    <= 1'b0;
            step_en <= 1'b0;
            if (frame_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (frame_tick) begin
                        state <= SNAP;
                        busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    dx_s   <= doodle_x;
                    dy_s   <= doodle_y;
                    fall_s <= falling;
                    hit_f  <= 1'b0;
                    idx    <= '0;
                    state  <= SCAN;
                end
                SCAN: begin
                    if (hit_now && !hit_f) begin
                        hit_f   <= 1'b1;
                        hit_idx <= idx;
                        hit_y   <= ty[idx];
                    end
                    idx <= idx + 1'b1;
                    // last entry resolves directly into the report outputs
                    if (last) begin
                        state <= REPORT;
                        land  <= hit_any;
                        if (hit_any) begin
                            land_idx <= hit_f ? hit_idx : idx;
                            land_y   <= hit_f ? hit_y : ty[idx];
                        end
                        miss <= !hit_any
                             && ({1'b0, dy_s} >= 11'(V_RES));
                        if (fcnt == CNT_W'(FRAME_DIV - 1)) begin
                            fcnt    <= '0;
                            step_en <= 1'b1;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                REPORT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_doodle_frame_scheduler.sv
// Scoreboard bench for doodle_frame_scheduler.
// Expected reports are queued at each tick and checked at REPORT.
module tb_doodle_frame_scheduler;

    localparam int FD = 2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       falling;
    logic [9:0] doodle_x;
    logic [9:0] doodle_y;
    logic       busy;
    logic       step_en;
    logic       land;
    logic [2:0] land_idx;
    logic [9:0] land_y;
    logic       miss;
    logic       overrun;

    doodle_frame_scheduler_if #(.IDX_W(3)) wr_if ();

    doodle_frame_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .falling    (falling),
        .doodle_x   (doodle_x),
        .doodle_y   (doodle_y),
        .wr         (wr_if.slave),
        .busy       (busy),
        .step_en    (step_en),
        .land       (land),
        .land_idx   (land_idx),
        .land_y     (land_y),
        .miss       (miss),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit l;
        int idx;
        int y;
        bit m;
        bit s;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   sv[8];
    int   sx[8];
    int   sy[8];
    int   frames = 0;
    bit   ov_exp = 0;
    int   li_exp = 0;
    int   ly_exp = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(int dx, int dy, bit f);
        exp_t e;
        e = '{0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            if (!e.l && sv[i] != 0 && f
                && dx + 20 >= sx[i] && dx <= sx[i] + 83
                && dy >= sy[i] && dy <= sy[i] + 4) begin
                e.l   = 1;
                e.idx = i;
                e.y   = sy[i];
            end
        end
        e.m = !e.l && dy >= 480;
        return e;
    endfunction

    task automatic wr_entry(int i, int x, int y, bit v);
        @(posedge Clk);
        #1;
        wr_if.plat_we    = 1'b1;
        wr_if.plat_idx   = 3'(i);
        wr_if.plat_x     = 10'(x);
        wr_if.plat_y     = 10'(y);
        wr_if.plat_valid = v;
        @(posedge Clk);
        #1;
        wr_if.plat_we = 1'b0;
        sv[i] = v;
        sx[i] = x;
        sy[i] = y;
    endtask

    // xt: extra tick cycle, wc: in-scan write cycle, rc: reset cycle
    task automatic frame(int dx, int dy, bit f,
                         int xt, int wc, int wi, int wx, int wy,
                         bit wv, int rc);
        exp_t e;
        int   stray;
        bit   rst_hit;
        stray   = 0;
        rst_hit = 0;
        @(posedge Clk);
        #1;
        doodle_x   = 10'(dx);
        doodle_y   = 10'(dy);
        falling    = f;
        frame_tick = 1'b1;
        e = model(dx, dy, f);
        frames++;
        e.s = (frames % FD == 0);
        sb.push_back(e);
        @(negedge Clk);
        chk("busy_c0", busy, 0);
        for (int c = 1; c <= 11; c++) begin
            @(posedge Clk);
            #1;
            frame_tick = (c == xt);
            if (c == 2) begin
                doodle_x = 10'(dx) ^ 10'h155;
                doodle_y = 10'd0;
                falling  = !f;
            end
            wr_if.plat_we = (c == wc);
            if (c == wc) begin
                wr_if.plat_idx   = 3'(wi);
                wr_if.plat_x     = 10'(wx);
                wr_if.plat_y     = 10'(wy);
                wr_if.plat_valid = wv;
                sv[wi] = wv;
                sx[wi] = wx;
                sy[wi] = wy;
            end
            Reset = (c == rc);
            if (c == rc) begin
                rst_hit = 1;
                for (int i = 0; i < 8; i++) sv[i] = 0;
                frames = 0;
                ov_exp = 0;
                li_exp = 0;
                ly_exp = 0;
                void'(sb.pop_back());
            end
            if (c == xt && c <= 10 && !rst_hit) ov_exp = 1;
            @(negedge Clk);
            chk("busy", busy, (!rst_hit && c <= 10) ? 1 : 0);
            if (c == 10 && !rst_hit) begin
                e = sb.pop_front();
                chk("land", land, e.l);
                chk("miss", miss, e.m);
                chk("step_en", step_en, e.s);
                if (e.l) begin
                    li_exp = e.idx;
                    ly_exp = e.y;
                end
                chk("land_idx", land_idx, li_exp);
                chk("land_y", land_y, ly_exp);
            end else begin
                stray += int'(land) + int'(miss) + int'(step_en);
            end
        end
        chk("stray_pulse", stray, 0);
        chk("overrun", overrun, ov_exp);
    endtask

    task automatic plain(int dx, int dy, bit f);
        frame(dx, dy, f, -1, -1, 0, 0, 0, 0, -1);
    endtask

    initial begin
        Reset            = 1'b1;
        frame_tick       = 1'b0;
        falling          = 1'b0;
        doodle_x         = '0;
        doodle_y         = '0;
        wr_if.plat_we    = 1'b0;
        wr_if.plat_idx   = '0;
        wr_if.plat_x     = '0;
        wr_if.plat_y     = '0;
        wr_if.plat_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sv[i] = 0;
            sx[i] = 0;
            sy[i] = 0;
        end
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_busy", busy, 0);
        chk("rst_land", land, 0);
        chk("rst_miss", miss, 0);
        chk("rst_step", step_en, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_land_idx", land_idx, 0);
        chk("rst_land_y", land_y, 0);

        wr_entry(3, 100, 300, 1);
        plain(130, 302, 1);
        plain(130, 302, 0);
        plain(60, 300, 1);
        plain(80, 300, 1);
        plain(183, 300, 1);
        plain(184, 300, 1);
        plain(130, 305, 1);

        wr_entry(2, 100, 300, 1);
        wr_entry(5, 90, 301, 1);
        wr_entry(3, 100, 300, 0);
        frame(130, 302, 1, -1, 4, 2, 100, 300, 0, -1);
        plain(130, 302, 1);

        plain(320, 480, 1);
        plain(320, 479, 1);

        frame(130, 302, 1, 5, -1, 0, 0, 0, 0, -1);
        frame(130, 302, 1, 10, -1, 0, 0, 0, 0, -1);
        plain(130, 302, 1);

        frame(130, 302, 1, -1, -1, 0, 0, 0, 0, 6);
        plain(130, 302, 1);
        plain(320, 480, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
